// File: rtl/mux_data_pkg.sv
// Shared types and helpers for the multi-source data stream mux.
package mux_data_pkg;

  // Burst-tracking state: IDLE samples the select, BURST holds a locked source.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Width of a select/source-id field; never narrower than one bit.
  function automatic int sel_width(input int num_src);
    if (num_src <= 2) begin
      return 1;
    end
    return $clog2(num_src);
  endfunction

  // Bit offset of lane `lane` of source `src` inside the flattened source bus.
  function automatic int lane_lsb(input int src, input int lane,
                                  input int lanes, input int lane_w);
    return (src * lanes + lane) * lane_w;
  endfunction

endpackage

// File: rtl/mux_data_oreg.sv
// Single output register stage with valid/ready: accepts a new payload
// whenever it is empty or its current contents are being taken downstream,
// and holds payload stable while stalled.
module mux_data_oreg #(
  parameter int PAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PAY_W-1:0] payload_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [PAY_W-1:0] payload_o,
  output logic             can_load_o
);

  logic             valid_q, valid_d;
  logic [PAY_W-1:0] payload_q, payload_d;

  assign can_load_o = ~valid_q | ready_i;
  assign valid_o    = valid_q;
  assign payload_o  = payload_q;

  // Next state: load on accept, drain when taken, otherwise hold.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (ready_i) begin
      valid_d   = 1'b0;
    end
  end

  // Register stage; reset drops any held beat and clears the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/mux_data_stream.sv
// NUM_SRC-to-1 multi-lane stream mux. The selected source is locked for a
// whole burst (through its last beat) so a select change never splits a
// transfer; one registered output stage gives one-cycle latency at full rate.
module mux_data_stream
  import mux_data_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int LANES   = 8,
  parameter  int LANE_W  = 256,
  localparam int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SEL_W-1:0]                  sel_i,
  input  logic [NUM_SRC-1:0]                src_valid_i,
  input  logic [NUM_SRC-1:0]                src_last_i,
  input  logic [NUM_SRC*LANES*LANE_W-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]                src_ready_o,
  output logic                              dst_valid_o,
  output logic                              dst_last_o,
  output logic [LANES*LANE_W-1:0]           dst_data_o,
  output logic [SEL_W-1:0]                  dst_src_o,
  input  logic                              dst_ready_i,
  output logic                              busy_o,
  output logic                              sel_err_o
);

  localparam int DATA_W = LANES * LANE_W;
  localparam int PAY_W  = DATA_W + 1 + SEL_W;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic              sel_err_q, sel_err_d;

  logic              sel_in_range;
  logic [SEL_W-1:0]  grant;
  logic              grant_ok;
  logic              can_load;
  logic              accept;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic [PAY_W-1:0]  oreg_payload;

  // Out-of-range selects only exist when NUM_SRC is not a power of two.
  assign sel_in_range = (int'(sel_i) < NUM_SRC);

  // In BURST the locked source owns the output; sel_i is ignored entirely.
  assign grant    = (state_q == BURST) ? cur_q : sel_i;
  assign grant_ok = (state_q == BURST) | sel_in_range;
  assign accept   = grant_ok & can_load & g_valid;

  // Route the granted source's valid, last and lanes; nothing when no match.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant == SEL_W'(s)) begin
        g_valid = src_valid_i[s];
        g_last  = src_last_i[s];
        for (int l = 0; l < LANES; l++) begin
          g_data[l*LANE_W +: LANE_W] =
            src_data_i[lane_lsb(s, l, LANES, LANE_W) +: LANE_W];
        end
      end
    end
  end

  // Only the granted source sees ready, and only when the output can load.
  always_comb begin
    src_ready_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_ready_o[s] = grant_ok & can_load & (grant == SEL_W'(s));
    end
  end

  // Burst tracking: lock on a non-last first beat, release on the last beat.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    sel_err_d = (state_q == IDLE) & ~sel_in_range;
    if (accept) begin
      if ((state_q == IDLE) && !g_last) begin
        state_d = BURST;
        cur_d   = grant;
      end else if ((state_q == BURST) && g_last) begin
        state_d = IDLE;
      end
    end
  end

  // Control registers; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign busy_o    = (state_q == BURST);
  assign sel_err_o = sel_err_q;

  mux_data_oreg #(
    .PAY_W (PAY_W)
  ) u_oreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .payload_i  ({g_last, grant, g_data}),
    .ready_i    (dst_ready_i),
    .valid_o    (dst_valid_o),
    .payload_o  (oreg_payload),
    .can_load_o (can_load)
  );

  assign dst_data_o = oreg_payload[DATA_W-1:0];
  assign dst_src_o  = oreg_payload[DATA_W +: SEL_W];
  assign dst_last_o = oreg_payload[PAY_W-1];

endmodule
